// File: rtl/read_burst_capture.sv
// Byte-lane read burst capture: delays each accepted read by rd_lat cycles, then assembles one BL8 burst.
// Optional READ_BURST_CAPTURE_STATS_EN adds burst/reject counters.
module read_burst_capture #(
    parameter int LAT_WIDTH = 5,
    parameter int DQ_NUM    = 8
) (
    input  logic                   oclk_div,
    input  logic                   rst_n,
    input  logic [4*DQ_NUM-1:0]    din,
    input  logic                   rd_start,
    input  logic [LAT_WIDTH-1:0]   rd_lat,
    input  logic                   nibble_sel,
    output logic [8*DQ_NUM-1:0]    dout,
    output logic                   dout_valid,
    output logic                   rd_pending,
    output logic                   err_overlap
`ifdef READ_BURST_CAPTURE_STATS_EN
    ,
    output logic [15:0]            stat_bursts,
    output logic [7:0]             stat_rejects
`endif
);

    localparam int DEPTH = 2 ** LAT_WIDTH;

    logic                  start_prev_reg;
    logic                  accept;
    logic [DEPTH-1:1]      dl_reg;
    logic [DEPTH-1:0]      line;
    logic [DEPTH-1:1]      live;
    logic                  tap;
    logic [1:0]            v_reg;
    logic [4*DQ_NUM-1:0]   h1_reg;
    logic [4*DQ_NUM-1:0]   h2_reg;
    logic [8*DQ_NUM-1:0]   even_bits;
    logic [8*DQ_NUM-1:0]   odd_bits;
    logic [8*DQ_NUM-1:0]   burst_next;
    logic [8*DQ_NUM-1:0]   dout_reg;
    logic                  dout_valid_reg;
    logic                  err_reg;

    assign accept = rd_start & ~start_prev_reg;

    // Entry 0 is the start itself, so rd_lat=0 taps the current cycle.
    assign line = {dl_reg, accept};
    assign tap  = line[rd_lat];

    // Only entries at or below the tap still belong to an outstanding burst.
    genvar gi;
    generate
        for (gi = 1; gi < DEPTH; gi++) begin : g_live
            assign live[gi] = dl_reg[gi] & (LAT_WIDTH'(gi) <= rd_lat);
        end
    endgenerate

    // At assembly time h2 = word c, h1 = word c+1, din = word c+2.
    generate
        for (gi = 0; gi < DQ_NUM; gi++) begin : g_dq
            for (genvar gb = 0; gb < 8; gb++) begin : g_beat
                if (gb < 4) begin : g_even_lo
                    assign even_bits[8*gb+gi] = h2_reg[4*gi+gb];
                end else begin : g_even_hi
                    assign even_bits[8*gb+gi] = h1_reg[4*gi+gb-4];
                end
                if (gb + 2 < 4) begin : g_odd_a
                    assign odd_bits[8*gb+gi] = h2_reg[4*gi+gb+2];
                end else if (gb + 2 < 8) begin : g_odd_b
                    assign odd_bits[8*gb+gi] = h1_reg[4*gi+gb-2];
                end else begin : g_odd_c
                    assign odd_bits[8*gb+gi] = din[4*gi+gb-6];
                end
            end
        end
    endgenerate

    assign burst_next = nibble_sel ? odd_bits : even_bits;

    always_ff @(posedge oclk_div) begin
        if (!rst_n) begin
            start_prev_reg <= 1'b0;
            err_reg        <= 1'b0;
            dl_reg         <= '0;
            h1_reg         <= '0;
            h2_reg         <= '0;
            v_reg          <= '0;
            dout_valid_reg <= 1'b0;
            dout_reg       <= '0;
        end else begin
            start_prev_reg <= rd_start;
            err_reg        <= rd_start & start_prev_reg;
            dl_reg         <= line[DEPTH-2:0];
            h1_reg         <= din;
            h2_reg         <= h1_reg;
            v_reg          <= {v_reg[0], tap};
            dout_valid_reg <= v_reg[1];
            if (v_reg[1]) begin
                dout_reg <= burst_next;
            end
        end
    end

    assign dout        = dout_reg;
    assign dout_valid  = dout_valid_reg;
    assign err_overlap = err_reg;
    assign rd_pending  = (|live) | (|v_reg) | dout_valid_reg;

`ifdef READ_BURST_CAPTURE_STATS_EN
    logic [15:0] bursts_reg;
    logic [7:0]  rejects_reg;

    always_ff @(posedge oclk_div) begin
        if (!rst_n) begin
            bursts_reg  <= '0;
            rejects_reg <= '0;
        end else begin
            bursts_reg <= bursts_reg + {15'd0, dout_valid_reg};
            if (err_reg && rejects_reg != 8'hFF) begin
                rejects_reg <= rejects_reg + 8'd1;
            end
        end
    end

    assign stat_bursts  = bursts_reg;
    assign stat_rejects = rejects_reg;
`endif

endmodule
